// File: rtl/prog_controller_pkg.sv
// Shared encodings for the program-load / run controller: FSM states,
// halt reason codes and the CPU reset hold length.
package prog_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CPURST = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        HR_NONE    = 2'd0,
        HR_BTN     = 2'd1,
        HR_BP      = 2'd2,
        HR_TIMEOUT = 2'd3
    } halt_reason_e;

    localparam logic [1:0] CPURST_LEN = 2'd2;

endpackage

// File: rtl/prog_controller_mem.sv
// 16x8 program store: synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives reset.
module prog_mem16x8 (
    input  logic       clk_cpu,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [16];

    always_ff @(posedge clk_cpu) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_controller.sv
// Program loader and run/step/breakpoint controller for a small CPU.
//
// state   | meaning
// IDLE    | CPU held in reset, program may be loaded
// CPURST  | CPU reset pulse (CPURST_LEN cycles) before entering target
// RUN     | CPU free-running until a halt condition
// STEP    | single enabled CPU cycle, then back to HALT
// HALT    | CPU stopped, out of reset, program may be patched
module prog_controller
    import prog_controller_pkg::*;
#(
    parameter logic [7:0] MAX_CYCLES = 8'd200
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic       halt_btn,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    output logic [7:0] inst,
    output logic       cpu_reset,
    output logic       cpu_en,
    output logic [2:0] state,
    output logic [1:0] halt_reason,
    output logic [7:0] cycle_cnt
);

    state_e       state_q, state_d;
    state_e       target_q, target_d;
    halt_reason_e reason_q, reason_d;
    logic [1:0]   rst_cnt_q, rst_cnt_d;
    logic [7:0]   cycle_cnt_q, cycle_cnt_d;
    logic         resume_q, resume_d;
    logic         cnt_clr;
    logic         cpu_en_c;
    logic         bp_hit;

    // Breakpoint is masked for one cycle after resuming so the CPU can leave it.
    assign bp_hit = bp_en && (pc == bp_addr) && !resume_q;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        reason_d  = reason_q;
        rst_cnt_d = rst_cnt_q;
        resume_d  = 1'b0;
        cnt_clr   = 1'b0;
        cpu_en_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_btn || run_btn) begin
                    state_d   = ST_CPURST;
                    target_d  = step_btn ? ST_HALT : ST_RUN;
                    rst_cnt_d = CPURST_LEN - 2'd1;
                end
            end
            ST_CPURST: begin
                cnt_clr  = 1'b1;
                reason_d = HR_NONE;
                if (rst_cnt_q == 2'd0) begin
                    state_d = target_q;
                end else begin
                    rst_cnt_d = rst_cnt_q - 2'd1;
                end
            end
            ST_RUN: begin
                if (halt_btn) begin
                    state_d  = ST_HALT;
                    reason_d = HR_BTN;
                end else if (bp_hit) begin
                    state_d  = ST_HALT;
                    reason_d = HR_BP;
                end else if (cycle_cnt_q == MAX_CYCLES) begin
                    state_d  = ST_HALT;
                    reason_d = HR_TIMEOUT;
                end else begin
                    cpu_en_c = 1'b1;
                end
            end
            ST_STEP: begin
                cpu_en_c = 1'b1;
                state_d  = ST_HALT;
                reason_d = HR_BTN;
            end
            ST_HALT: begin
                if (halt_btn) begin
                    state_d = ST_HALT;
                end else if (step_btn) begin
                    state_d  = ST_STEP;
                    reason_d = HR_NONE;
                end else if (run_btn) begin
                    state_d  = ST_RUN;
                    reason_d = HR_NONE;
                    resume_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cycle_cnt_d = cycle_cnt_q;
        if (cnt_clr) begin
            cycle_cnt_d = 8'd0;
        end else if (cpu_en && (cycle_cnt_q != 8'hFF)) begin
            cycle_cnt_d = cycle_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            target_q    <= ST_RUN;
            reason_q    <= HR_NONE;
            rst_cnt_q   <= 2'd0;
            cycle_cnt_q <= 8'd0;
            resume_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            reason_q    <= reason_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            resume_q    <= resume_d;
        end
    end

    // Gating with reset keeps the CPU from taking one more step on the reset edge.
    assign cpu_en      = cpu_en_c && !reset;
    assign cpu_reset   = (state_q == ST_IDLE) || (state_q == ST_CPURST);
    assign load_ready  = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign state       = state_q;
    assign halt_reason = reason_q;
    assign cycle_cnt   = cycle_cnt_q;

    prog_mem16x8 u_mem (
        .clk_cpu (clk_cpu),
        .we      (load_valid && load_ready),
        .waddr   (load_addr),
        .wdata   (load_data),
        .raddr   (pc),
        .rdata   (inst)
    );

endmodule

// File: tb/tb_prog_controller.sv
// Directed bench for prog_controller with a tiny CPU model that advances pc on cpu_en.
module tb_prog_controller;

    logic       clk_cpu = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_addr = 4'd0;
    logic [7:0] load_data = 8'd0;
    logic       run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0;
    logic       bp_en = 1'b0;
    logic [3:0] bp_addr = 4'd0;
    logic [3:0] pc, pc_cpu = 4'd0, pc_ovr = 4'd0;
    logic       pc_sel = 1'b0;
    logic [7:0] inst;
    logic       cpu_reset, cpu_en;
    logic [2:0] state;
    logic [1:0] halt_reason;
    logic [7:0] cycle_cnt;
    logic [7:0] exp_mem [16];

    int tests = 0;
    int failed = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_CPURST = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3, S_HALT = 3'd4;

    prog_controller #(.MAX_CYCLES(8'd10)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .inst(inst),
        .cpu_reset(cpu_reset), .cpu_en(cpu_en),
        .state(state), .halt_reason(halt_reason), .cycle_cnt(cycle_cnt)
    );

    always #5 clk_cpu = ~clk_cpu;

    assign pc = pc_sel ? pc_ovr : pc_cpu;

    always @(posedge clk_cpu) begin
        if (cpu_reset) pc_cpu <= 4'd0;
        else if (cpu_en) pc_cpu <= pc_cpu + 4'd1;
    end

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tests++; if (state !== S_IDLE) begin failed++; $display("FAIL reset_state got %0d exp %0d", state, S_IDLE); end
        tests++; if (cycle_cnt !== 8'd0) begin failed++; $display("FAIL reset_cnt got %0d exp 0", cycle_cnt); end
        tests++; if (halt_reason !== 2'd0) begin failed++; $display("FAIL reset_reason got %0d exp 0", halt_reason); end
        tests++; if (cpu_en !== 1'b0) begin failed++; $display("FAIL reset_cpu_en got %b exp 0", cpu_en); end
        tests++; if (cpu_reset !== 1'b1) begin failed++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
        tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
    endtask

    task automatic test_load();
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_addr  = 4'(i);
            load_data  = 8'(i * 17);
            exp_mem[i] = 8'(i * 17);
            #1;
            tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL load_ready[%0d] got %b exp 1", i, load_ready); end
            tick();
        end
        load_valid = 1'b0;
        pc_sel = 1'b1;
        pc_ovr = 4'd3;
        #1;
        tests++; if (inst !== 8'h33) begin failed++; $display("FAIL load_inst_pc3 got %02h exp 33", inst); end
        pc_ovr = 4'd15;
        #1;
        tests++; if (inst !== 8'hFF) begin failed++; $display("FAIL load_inst_pc15 got %02h exp ff", inst); end
        pc_sel = 1'b0;
        #1;
    endtask

    task automatic test_startup();
        bp_en = 1'b1;
        bp_addr = 4'h5;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tests++; if (state !== S_CPURST || cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin failed++; $display("FAIL start_rst1 got st=%0d rst=%b en=%b exp st=1 rst=1 en=0", state, cpu_reset, cpu_en); end
        tick();
        tests++; if (state !== S_CPURST || cpu_reset !== 1'b1) begin failed++; $display("FAIL start_rst2 got st=%0d rst=%b exp st=1 rst=1", state, cpu_reset); end
        tick();
        tests++; if (state !== S_RUN || cpu_reset !== 1'b0) begin failed++; $display("FAIL start_run got st=%0d rst=%b exp st=2 rst=0", state, cpu_reset); end
        for (int k = 0; k < 5; k++) begin
            tests++; if (cpu_en !== 1'b1 || cycle_cnt !== 8'(k) || pc !== 4'(k) || inst !== 8'(k * 17)) begin
                failed++; $display("FAIL start_count[%0d] got en=%b cnt=%0d pc=%0d inst=%02h", k, cpu_en, cycle_cnt, pc, inst);
            end
            tick();
        end
    endtask

    task automatic test_breakpoint();
        tests++; if (state !== S_RUN || pc !== 4'd5 || cpu_en !== 1'b0) begin failed++; $display("FAIL bp_hit got st=%0d pc=%0d en=%b exp st=2 pc=5 en=0", state, pc, cpu_en); end
        tick();
        tests++; if (state !== S_HALT || halt_reason !== 2'd2 || cycle_cnt !== 8'd5 || pc !== 4'd5) begin
            failed++; $display("FAIL bp_halt got st=%0d rsn=%0d cnt=%0d pc=%0d exp 4/2/5/5", state, halt_reason, cycle_cnt, pc);
        end
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tests++; if (state !== S_RUN || halt_reason !== 2'd0 || pc !== 4'd5 || cpu_en !== 1'b1) begin
            failed++; $display("FAIL bp_resume got st=%0d rsn=%0d pc=%0d en=%b exp 2/0/5/1", state, halt_reason, pc, cpu_en);
        end
        tick();
        tests++; if (state !== S_RUN || pc !== 4'd6 || cycle_cnt !== 8'd6 || cpu_en !== 1'b1) begin
            failed++; $display("FAIL bp_advance got st=%0d pc=%0d cnt=%0d en=%b exp 2/6/6/1", state, pc, cycle_cnt, cpu_en);
        end
    endtask

    task automatic test_priority();
        halt_btn = 1'b1;
        run_btn = 1'b1;
        #1;
        tests++; if (cpu_en !== 1'b0) begin failed++; $display("FAIL prio_en got %b exp 0", cpu_en); end
        tick();
        halt_btn = 1'b0;
        run_btn = 1'b0;
        tests++; if (state !== S_HALT || halt_reason !== 2'd1 || pc !== 4'd6 || cycle_cnt !== 8'd6) begin
            failed++; $display("FAIL prio_halt got st=%0d rsn=%0d pc=%0d cnt=%0d exp 4/1/6/6", state, halt_reason, pc, cycle_cnt);
        end
    endtask

    task automatic test_step();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tests++; if (state !== S_STEP || halt_reason !== 2'd0 || cpu_en !== 1'b1) begin
            failed++; $display("FAIL step_pulse got st=%0d rsn=%0d en=%b exp 3/0/1", state, halt_reason, cpu_en);
        end
        tick();
        tests++; if (state !== S_HALT || halt_reason !== 2'd1 || cycle_cnt !== 8'd7 || pc !== 4'd7 || cpu_en !== 1'b0) begin
            failed++; $display("FAIL step_done got st=%0d rsn=%0d cnt=%0d pc=%0d en=%b exp 4/1/7/7/0", state, halt_reason, cycle_cnt, pc, cpu_en);
        end
        tick();
        tests++; if (state !== S_HALT || cycle_cnt !== 8'd7 || pc !== 4'd7) begin
            failed++; $display("FAIL step_hold got st=%0d cnt=%0d pc=%0d exp 4/7/7", state, cycle_cnt, pc);
        end
    endtask

    task automatic test_halt_load();
        load_valid = 1'b1;
        load_addr = 4'd7;
        load_data = 8'hA5;
        #1;
        tests++; if (load_ready !== 1'b1) begin failed++; $display("FAIL hload_ready got %b exp 1", load_ready); end
        tick();
        load_valid = 1'b0;
        exp_mem[7] = 8'hA5;
        tests++; if (inst !== 8'hA5 || state !== S_HALT || cpu_en !== 1'b0 || pc !== 4'd7) begin
            failed++; $display("FAIL hload_inst got inst=%02h st=%0d en=%b pc=%0d exp a5/4/0/7", inst, state, cpu_en, pc);
        end
    endtask

    task automatic test_reset_midrun();
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tests++; if (state !== S_RUN || cpu_en !== 1'b1) begin failed++; $display("FAIL mrst_run got st=%0d en=%b exp 2/1", state, cpu_en); end
        tick();
        tests++; if (cpu_en !== 1'b1 || cycle_cnt !== 8'd8) begin failed++; $display("FAIL mrst_cnt got en=%b cnt=%0d exp 1/8", cpu_en, cycle_cnt); end
        tests++; if (load_ready !== 1'b0) begin failed++; $display("FAIL mrst_ready got %b exp 0", load_ready); end
        reset = 1'b1;
        #1;
        tests++; if (cpu_en !== 1'b0) begin failed++; $display("FAIL mrst_en got %b exp 0", cpu_en); end
        tick();
        reset = 1'b0;
        tests++; if (state !== S_IDLE || cpu_reset !== 1'b1 || cycle_cnt !== 8'd0 || halt_reason !== 2'd0) begin
            failed++; $display("FAIL mrst_idle got st=%0d rst=%b cnt=%0d rsn=%0d exp 0/1/0/0", state, cpu_reset, cycle_cnt, halt_reason);
        end
        pc_sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pc_ovr = 4'(i);
            #1;
            tests++; if (inst !== exp_mem[i]) begin failed++; $display("FAIL mrst_mem[%0d] got %02h exp %02h", i, inst, exp_mem[i]); end
        end
        pc_sel = 1'b0;
        #1;
    endtask

    task automatic test_idle_step();
        halt_btn = 1'b1;
        step_btn = 1'b1;
        tick();
        halt_btn = 1'b0;
        step_btn = 1'b0;
        tests++; if (state !== S_CPURST) begin failed++; $display("FAIL istep_rst got st=%0d exp 1", state); end
        repeat (2) tick();
        tests++; if (state !== S_HALT || cpu_reset !== 1'b0 || cpu_en !== 1'b0 || cycle_cnt !== 8'd0 || halt_reason !== 2'd0) begin
            failed++; $display("FAIL istep_halt got st=%0d rst=%b en=%b cnt=%0d rsn=%0d exp 4/0/0/0/0", state, cpu_reset, cpu_en, cycle_cnt, halt_reason);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int budget = 40;
        bp_en = 1'b0;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        while (state !== S_HALT && budget > 0) begin
            if (cpu_en === 1'b1) n++;
            budget--;
            tick();
        end
        tests++; if (budget == 0) begin failed++; $display("FAIL tmo_wait got no HALT exp HALT within 40 cycles"); end
        tests++; if (n != 10) begin failed++; $display("FAIL tmo_pulses got %0d exp 10", n); end
        tests++; if (halt_reason !== 2'd3 || cycle_cnt !== 8'd10) begin
            failed++; $display("FAIL tmo_reason got rsn=%0d cnt=%0d exp 3/10", halt_reason, cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_startup();
        test_breakpoint();
        test_priority();
        test_step();
        test_halt_load();
        test_reset_midrun();
        test_idle_step();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
